// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, dataWidth data bits LSB first, optional parity, stop bit.
// Each bit is decided by a 3-sample majority around mid-bit; results are one-cycle pulses.
module uart_rx #(
  parameter int dataWidth     = 8,
  parameter int prescaleWidth = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_in,
  input  logic [prescaleWidth-1:0] prescale,
  input  logic                     par_en,
  input  logic                     par_type,
  output logic [dataWidth-1:0]     p_data,
  output logic                     data_valid,
  output logic                     par_err,
  output logic                     stop_err,
  output logic                     busy
);

  localparam int BCW = (dataWidth > 1) ? $clog2(dataWidth) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [prescaleWidth-1:0] ONE      = prescaleWidth'(1);
  localparam logic [prescaleWidth-1:0] TWO      = prescaleWidth'(2);
  localparam logic [BCW-1:0]           LAST_BIT = BCW'(dataWidth - 1);

  logic [2:0]               r_state;
  logic [prescaleWidth-1:0] r_edge_cnt;
  logic [BCW-1:0]           r_bit_cnt;
  logic [prescaleWidth-1:0] r_ps;
  logic                     r_par_en;
  logic                     r_par_type;
  logic [2:0]               r_samp;
  logic [dataWidth-1:0]     r_shift;
  logic                     r_par_flag;

  logic [prescaleWidth-1:0] w_half;
  logic                     w_last_edge;
  logic                     w_maj;

  assign w_half      = r_ps >> 1;
  assign w_last_edge = (r_edge_cnt == r_ps - ONE);
  assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_ps       <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_samp     <= '0;
      r_shift    <= '0;
      r_par_flag <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; a later assignment in this block wins.
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;

      if (r_state != S_IDLE) begin
        if (r_edge_cnt == w_half - ONE) r_samp[0] <= rx_in;
        if (r_edge_cnt == w_half)       r_samp[1] <= rx_in;
        if (r_edge_cnt == w_half + ONE) r_samp[2] <= rx_in;
        r_edge_cnt <= w_last_edge ? '0 : r_edge_cnt + ONE;
      end

      case (r_state)
        S_IDLE: begin
          if (!rx_in) begin
            // The detecting edge is count 0 of the start bit, so the next edge is count 1.
            r_state    <= S_START;
            r_edge_cnt <= ONE;
            r_ps       <= prescale;
            r_par_en   <= par_en;
            r_par_type <= par_type;
            r_par_flag <= 1'b0;
            r_bit_cnt  <= '0;
          end
        end
        S_START: begin
          if (r_edge_cnt == w_half + TWO && w_maj) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else if (w_last_edge) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_last_edge) begin
            r_shift <= {w_maj, r_shift[dataWidth-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_last_edge) begin
            r_par_flag <= (w_maj != ((^r_shift) ^ r_par_type));
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_last_edge) begin
            r_state  <= S_IDLE;
            stop_err <= ~w_maj;
            par_err  <= r_par_flag;
            if (w_maj && !r_par_flag) begin
              p_data     <= r_shift;
              data_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built from the line format and every result
// pulse is timed and classified by a frame-level reference model.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_type;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stop_err;
  logic          busy;

  uart_rx #(.dataWidth(DW), .prescaleWidth(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .prescale  (prescale),
    .par_en    (par_en),
    .par_type  (par_type),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stop_err  (stop_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // cyc at a falling edge equals the index of the next rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            t;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] d;
  } ev_t;

  ev_t evq[$];
  ev_t mon_ev;

  always @(negedge clk) begin
    if (data_valid || par_err || stop_err) begin
      mon_ev.t  = cyc;
      mon_ev.dv = data_valid;
      mon_ev.pe = par_err;
      mon_ev.se = stop_err;
      mon_ev.d  = p_data;
      evq.push_back(mon_ev);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_pdata = '0;

  // Drives one whole frame starting at a falling edge; returns the start-detect edge index.
  task automatic drive_frame(input logic [DW-1:0] d, input int ps, input bit pe,
                             input bit par_bit, input bit stop_bit, output int e0);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (pe) q.push_back(par_bit);
    q.push_back(stop_bit);
    e0 = cyc;
    foreach (q[i]) begin
      rx_in = q[i];
      repeat (ps) @(negedge clk);
    end
  endtask

  task automatic expect_frame(input string nm, input logic [DW-1:0] d, input int ps,
                              input bit pe, input bit pt, input bit par_bit,
                              input bit stop_bit, input int e0);
    ev_t ev;
    int  exp_t;
    bit  exp_pe, exp_se, exp_dv;
    exp_t  = e0 + (pe ? 11 : 10) * ps;
    exp_pe = pe && (par_bit != ((^d) ^ pt));
    exp_se = !stop_bit;
    exp_dv = !exp_pe && !exp_se;
    if (exp_dv) exp_pdata = d;
    n_cmp++;
    if (evq.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no result pulse seen, required one at cycle %0d", nm, exp_t);
      return;
    end
    ev = evq.pop_front();
    n_cmp++;
    if (ev.t !== exp_t) begin
      n_bad++;
      $display("FAIL %s time: got cycle %0d, required %0d", nm, ev.t, exp_t);
    end
    n_cmp++;
    if ({ev.dv, ev.pe, ev.se} !== {exp_dv, exp_pe, exp_se}) begin
      n_bad++;
      $display("FAIL %s flags dv/pe/se: got %b%b%b, required %b%b%b",
               nm, ev.dv, ev.pe, ev.se, exp_dv, exp_pe, exp_se);
    end
    n_cmp++;
    if (ev.d !== exp_pdata) begin
      n_bad++;
      $display("FAIL %s p_data: got %h, required %h", nm, ev.d, exp_pdata);
    end
  endtask

  task automatic expect_quiet(input string nm);
    n_cmp++;
    if (evq.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d unexpected result pulse(s), required 0", nm, evq.size());
      evq.delete();
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy: got %b, required 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({p_data, data_valid, par_err, stop_err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got p_data=%h dv=%b pe=%b se=%b busy=%b, required all 0",
               p_data, data_valid, par_err, stop_err, busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    expect_quiet("reset_idle");
  endtask

  task automatic test_basic();
    int e0;
    prescale = 6'd8; par_en = 1'b1; par_type = 1'b0;
    drive_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, e0);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    expect_frame("basic", 8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, e0);
    expect_quiet("basic_after");
  endtask

  task automatic test_parity_err();
    int e0;
    prescale = 6'd8; par_en = 1'b1; par_type = 1'b1;
    drive_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, e0);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    expect_frame("parity_err", 8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b1, e0);
    n_cmp++;
    if (p_data !== exp_pdata) begin
      n_bad++;
      $display("FAIL parity_err hold: got p_data %h, required %h", p_data, exp_pdata);
    end
  endtask

  task automatic test_stop_err();
    int e0;
    prescale = 6'd16; par_en = 1'b0; par_type = 1'b0;
    drive_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, e0);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    expect_frame("stop_err", 8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, e0);
    expect_quiet("stop_err_after");
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    prescale = 6'd8; par_en = 1'b0;
    rx_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i == 1) rx_in = 1'b1;
    end
    n_cmp++;
    if (busy_cnt != 8 / 2 + 2) begin
      n_bad++;
      $display("FAIL glitch busy length: got %0d cycles, required %0d", busy_cnt, 8 / 2 + 2);
    end
    expect_quiet("glitch");
  endtask

  task automatic test_back_to_back();
    int e0a, e0b;
    prescale = 6'd16; par_en = 1'b0;
    drive_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, e0a);
    drive_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, e0b);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    expect_frame("b2b_first", 8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, e0a);
    expect_frame("b2b_second", 8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, e0b);
    expect_quiet("b2b_after");
  endtask

  task automatic test_line_low();
    int e0;
    prescale = 6'd8; par_en = 1'b0;
    rx_in = 1'b0;
    e0 = cyc;
    repeat (10 * 8 + 1) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL line_low restart busy: got %b, required 1", busy);
    end
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    expect_frame("line_low", 8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, e0);
    expect_quiet("line_low_after");
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d = 8'h5A;
    prescale = 6'd8; par_en = 1'b0;
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      repeat (8) @(negedge clk);
    end
    rst = 1'b1; rx_in = 1'b1;
    @(negedge clk);
    exp_pdata = '0;
    n_cmp++;
    if ({p_data, data_valid, par_err, stop_err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid outputs: got p_data=%h dv=%b pe=%b se=%b busy=%b, required all 0",
               p_data, data_valid, par_err, stop_err, busy);
    end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    expect_quiet("reset_mid_after");
  endtask

  task automatic test_loopback();
    logic [DW-1:0] bytes[10];
    int e0s[10];
    prescale = 6'd8; par_en = 1'b1; par_type = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bytes[i] = DW'($urandom);
      drive_frame(bytes[i], 8, 1'b1, ^bytes[i], 1'b1, e0s[i]);
      rx_in = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++)
      expect_frame($sformatf("loopback%0d", i), bytes[i], 8, 1'b1, 1'b0, ^bytes[i], 1'b1, e0s[i]);
    expect_quiet("loopback_after");
  endtask

  task automatic test_random();
    int ps_tab[3] = '{8, 16, 32};
    for (int i = 0; i < 12; i++) begin
      logic [DW-1:0] d;
      int ps, e0;
      bit pe, pt, pb, sb;
      d  = DW'($urandom);
      ps = ps_tab[$urandom_range(0, 2)];
      pe = 1'($urandom);
      pt = 1'($urandom);
      pb = (^d) ^ pt ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) != 0);
      prescale = PW'(ps); par_en = pe; par_type = pt;
      drive_frame(d, ps, pe, pb, sb, e0);
      prescale = PW'(ps_tab[$urandom_range(0, 2)]);
      par_en = 1'($urandom); par_type = 1'($urandom);
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      expect_frame($sformatf("random%0d", i), d, ps, pe, pt, pb, sb, e0);
    end
    expect_quiet("random_after");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_line_low();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the receive-side counterpart of the team's UART transmitter. It shares the same frame format: start bit 0, `dataWidth` data bits LSB first, optional parity bit, and stop bit 1. It recovers the serial line into a parallel word, checks parity and the stop bit, and presents one-cycle valid/error pulses to the system side.

## Interface
- `dataWidth`, default 8: data bits per frame.
- `prescaleWidth`, default 6: width of the `prescale` input and of the edge counter.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `rx_in` input, 1 bit: serial line; idles high. Already synchronised to `clk` upstream.
- `prescale` input, `prescaleWidth` bits: clocks per bit. Legal values are 8, 16 and 32.
- `par_en` input, 1 bit: 1 means a parity bit follows the data.
- `par_type` input, 1 bit: 0 selects even parity (parity bit = ^data), 1 selects odd parity (parity bit = ~^data).
- `p_data` output, `dataWidth` bits: last correctly received word.
- `data_valid` output, 1 bit: one-cycle pulse when `p_data` is updated.
- `par_err` output, 1 bit: one-cycle pulse when a frame has a parity mismatch.
- `stop_err` output, 1 bit: one-cycle pulse when a frame's stop bit is sampled 0.
- `busy` output, 1 bit: high while the FSM is outside IDLE.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE → START on the first edge that samples `rx_in`=0. Call this edge E0.
- At E0, latch `prescale`, `par_en` and `par_type`. Input changes mid-frame are ignored.
- Edge counter:
  - Runs 0..prescale-1 within each bit period.
  - The start bit occupies edges E0..E0+prescale-1.
  - Bit k occupies edges E0+k·prescale onward.
- Sampling:
  - Sample `rx_in` at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1.
  - The bit value is the majority of the 3 samples.
  - The value is valid from edge_cnt = prescale/2+2.
- START: if the start-bit majority is 1, treat it as a glitch. Return to IDLE at edge_cnt = prescale/2+2 and produce no output pulses.
- DATA:
  - Shift the majority value into bit index 0..dataWidth-1, LSB first.
  - A bit counter counts data bits.
  - After the last data bit, go to PARITY if `par_en`=1, else to STOP.
- PARITY:
  - Expected bit = ^data XOR `par_type`.
  - A mismatch sets an internal error flag.
- STOP: at edge_cnt = prescale-1, evaluate the frame and return to IDLE.
  - Stop majority = 1 and no parity error: load `p_data` and pulse `data_valid`.
  - Stop majority = 0: pulse `stop_err`.
  - Parity mismatch: pulse `par_err`.
  - Both errors may pulse together.
  - `data_valid` is never raised on an errored frame, and `p_data` keeps its previous value.
- IDLE may detect the next start bit on the edge immediately after returning. Back-to-back frames with no idle gap are supported.

## Timing
- Reset values:
  - `p_data`=0, `data_valid`=0, `par_err`=0, `stop_err`=0, `busy`=0.
  - FSM in IDLE; all counters 0.
- Frame length N = 10 with `par_en`=0 and N = 11 with `par_en`=1.
- Result pulses (`data_valid`, `par_err`, `stop_err`) are registered high in the cycle after edge E0+N·prescale-1, and last exactly 1 cycle.
- `busy`:
  - Rises in the cycle after E0.
  - Falls together with the result pulse, or at glitch rejection.
- Reset asserted mid-frame: on the next edge, abandon the frame, return all outputs to reset values, and enter IDLE. No pulses are generated for the abandoned frame.
- `rx_in` held low continuously:
  - Frame ends with `stop_err`.
  - IDLE then re-detects a start on the next edge.
- Arithmetic:
  - prescale/2 is a right shift.
  - The edge counter wraps from prescale-1 to 0 and never overflows `prescaleWidth`.

## Test plan
- Basic receive: prescale=8, `par_en`=1, `par_type`=0; drive 0xA5 as line sequence 0,1,0,1,0,0,1,0,1,0,1 with 8 clocks per bit. Expect `data_valid` pulse at E0+88, `p_data`=0xA5, no errors.
- Parity error: same frame with `par_type`=1. Expect a `par_err` pulse at E0+88, `data_valid` stays 0, and `p_data` keeps its prior value.
- Stop error: prescale=16, `par_en`=0, byte 0x3C with stop bit driven 0. Expect a `stop_err` pulse at E0+160 and no `data_valid`.
- Glitch start: prescale=8; drive `rx_in` low for 2 cycles, then high. Expect `busy` for at most 6 cycles, then no pulses, then IDLE.
- Back-to-back: prescale=16, `par_en`=0; frames 0x3C then 0xFF with no gap. Expect two `data_valid` pulses exactly 160 cycles apart with `p_data` 0x3C then 0xFF.
- Reset mid-frame and loopback:
  - Assert `rst` during the DATA bits of 0x5A. Expect no pulse and `busy`=0 after the next edge.
  - Then loop back 10 bytes from the UART transmitter at prescale=8 with even parity. Expect every byte to match.
